// File: rtl/reg_acc_arb.sv
// ---------------------------------------------------------------------------
// reg_acc_arb
//
// Purpose:
//   Shares the single register-bank access port between two requesters,
//   the SPI slave (slot 0) and the internal master (slot 1). Each slot has
//   a one-deep request buffer. A round-robin arbiter picks a winner, and one
//   access is sequenced at a time through IDLE -> ISSUE -> WAIT -> RESP.
//   The ack, read data and address echo are routed back to the requester
//   that issued the access. Everything runs in the i_clk domain.
//
// Optional feature:
//   REG_ARB_TMO_EN - when defined, a WAIT watchdog aborts an access after
//                    TMO_CYC cycles with no i_reg_ack. The abort returns
//                    data 0 and pulses o_tmo_err. When undefined, WAIT lasts
//                    until i_reg_ack and o_tmo_err stays 0.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_spi_reg_* / o_spi_reg_*     slot 0 request pulses and response
//   i_int_reg_* / o_int_reg_*     slot 1 request pulses and response
//   o_reg_wen/ren/addr/wdata      register-bank access, strobes 1 cycle
//   i_reg_ack, i_reg_rdata        register-bank completion and read data
//   o_ovf_err[1:0]                per-slot dropped-request pulse
//   o_tmo_err                     timeout abort pulse
// ---------------------------------------------------------------------------
module reg_acc_arb #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int TMO_CYC   = 255,
  parameter int TMO_CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_reg_wen,
  input  logic              i_spi_reg_ren,
  input  logic [REG_AW-1:0] i_spi_reg_addr,
  input  logic [REG_DW-1:0] i_spi_reg_wdata,
  output logic              o_spi_reg_wack,
  output logic              o_spi_reg_rack,
  output logic [REG_DW-1:0] o_spi_reg_data,
  output logic [REG_AW-1:0] o_spi_reg_addr,
  input  logic              i_int_reg_wen,
  input  logic              i_int_reg_ren,
  input  logic [REG_AW-1:0] i_int_reg_addr,
  input  logic [REG_DW-1:0] i_int_reg_wdata,
  output logic              o_int_reg_wack,
  output logic              o_int_reg_rack,
  output logic [REG_DW-1:0] o_int_reg_data,
  output logic [REG_AW-1:0] o_int_reg_addr,
  output logic              o_reg_wen,
  output logic              o_reg_ren,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [REG_DW-1:0] o_reg_wdata,
  input  logic              i_reg_ack,
  input  logic [REG_DW-1:0] i_reg_rdata,
  output logic [1:0]        o_ovf_err,
  output logic              o_tmo_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              lst_q;
  logic              tmo_hit;

  logic [1:0]        slot_vld_q;
  logic [1:0]        slot_wr_q;
  logic [REG_AW-1:0] slot_addr_q  [2];
  logic [REG_DW-1:0] slot_wdata_q [2];

  logic [1:0]        req_pulse;
  logic [1:0]        req_wr;
  logic [REG_AW-1:0] req_addr  [2];
  logic [REG_DW-1:0] req_wdata [2];
  logic [1:0]        slot_rel;
  logic [1:0]        slot_load;
  logic              issue_go;
  logic              resp_go;
  logic [REG_DW-1:0] rsp_data;

  // Wen together with ren counts as a write, so wr simply follows wen.
  assign req_pulse    = {i_int_reg_wen | i_int_reg_ren, i_spi_reg_wen | i_spi_reg_ren};
  assign req_wr       = {i_int_reg_wen, i_spi_reg_wen};
  assign req_addr[0]  = i_spi_reg_addr;
  assign req_addr[1]  = i_int_reg_addr;
  assign req_wdata[0] = i_spi_reg_wdata;
  assign req_wdata[1] = i_int_reg_wdata;

  // A slot is released in its RESP cycle. A new pulse in that same cycle
  // reloads the buffer instead of being treated as an overflow.
  assign slot_rel[0] = (state_q == ST_RESP) && !gnt_q;
  assign slot_rel[1] = (state_q == ST_RESP) &&  gnt_q;
  assign slot_load   = req_pulse & (~slot_vld_q | slot_rel);

  assign issue_go = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
  assign resp_go  = (state_q == ST_WAIT) && (state_d == ST_RESP);
  // Only a timeout abort reaches RESP without an ack, and it returns zero.
  assign rsp_data = i_reg_ack ? i_reg_rdata : '0;

`ifdef REG_ARB_TMO_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      lst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      if (state_q == ST_RESP) begin
        lst_q <= gnt_q;
      end
    end
  end

  // With both slots waiting, the slot that was not served last wins.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tmo_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|slot_vld_q) begin
          state_d = ST_ISSUE;
          gnt_d   = (&slot_vld_q) ? ~lst_q : slot_vld_q[1];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_reg_ack) begin
          state_d = ST_RESP;
        end
`ifdef REG_ARB_TMO_EN
        else if (tmo_cnt_q == TMO_CNT_W'(TMO_CYC - 1)) begin
          state_d = ST_RESP;
          tmo_hit = 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_vld_q <= '0;
      slot_wr_q  <= '0;
      o_ovf_err  <= '0;
      for (int k = 0; k < 2; k++) begin
        slot_addr_q[k]  <= '0;
        slot_wdata_q[k] <= '0;
      end
    end else begin
      o_ovf_err <= req_pulse & slot_vld_q & ~slot_rel;
      for (int k = 0; k < 2; k++) begin
        if (slot_load[k]) begin
          slot_vld_q[k]   <= 1'b1;
          slot_wr_q[k]    <= req_wr[k];
          slot_addr_q[k]  <= req_addr[k];
          slot_wdata_q[k] <= req_wdata[k];
        end else if (slot_rel[k]) begin
          slot_vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Bank address/data are loaded with the strobe and then held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_wen   <= 1'b0;
      o_reg_ren   <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
    end else begin
      o_reg_wen <= 1'b0;
      o_reg_ren <= 1'b0;
      if (issue_go) begin
        o_reg_wen   <=  slot_wr_q[gnt_d];
        o_reg_ren   <= ~slot_wr_q[gnt_d];
        o_reg_addr  <=  slot_addr_q[gnt_d];
        o_reg_wdata <=  slot_wdata_q[gnt_d];
      end
    end
  end

  // Response data/addr hold until the next response for the same slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spi_reg_wack <= 1'b0;
      o_spi_reg_rack <= 1'b0;
      o_spi_reg_data <= '0;
      o_spi_reg_addr <= '0;
      o_int_reg_wack <= 1'b0;
      o_int_reg_rack <= 1'b0;
      o_int_reg_data <= '0;
      o_int_reg_addr <= '0;
      o_tmo_err      <= 1'b0;
    end else begin
      o_spi_reg_wack <= 1'b0;
      o_spi_reg_rack <= 1'b0;
      o_int_reg_wack <= 1'b0;
      o_int_reg_rack <= 1'b0;
      o_tmo_err      <= 1'b0;
      if (resp_go) begin
        o_tmo_err <= tmo_hit;
        if (!gnt_q) begin
          o_spi_reg_wack <=  slot_wr_q[0];
          o_spi_reg_rack <= ~slot_wr_q[0];
          o_spi_reg_data <=  rsp_data;
          o_spi_reg_addr <=  slot_addr_q[0];
        end else begin
          o_int_reg_wack <=  slot_wr_q[1];
          o_int_reg_rack <= ~slot_wr_q[1];
          o_int_reg_data <=  rsp_data;
          o_int_reg_addr <=  slot_addr_q[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_acc_arb.sv
// ---------------------------------------------------------------------------
// tb_reg_acc_arb
//
// Purpose:
//   Self-checking bench for reg_acc_arb. A small register-bank model
//   acks each strobe one cycle later. Expected responses are queued when
//   requests are driven and popped when either requester sees an ack.
//   Build with +define+REG_ARB_TMO_EN to exercise the timeout abort.
// ---------------------------------------------------------------------------
module tb_reg_acc_arb;

  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int TMO = 16;

  typedef struct packed {
    logic          slot;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          tmo;
  } rsp_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_spi_reg_wen = 1'b0, i_spi_reg_ren = 1'b0;
  logic [AW-1:0] i_spi_reg_addr = '0;
  logic [DW-1:0] i_spi_reg_wdata = '0;
  logic          o_spi_reg_wack, o_spi_reg_rack;
  logic [DW-1:0] o_spi_reg_data;
  logic [AW-1:0] o_spi_reg_addr;
  logic          i_int_reg_wen = 1'b0, i_int_reg_ren = 1'b0;
  logic [AW-1:0] i_int_reg_addr = '0;
  logic [DW-1:0] i_int_reg_wdata = '0;
  logic          o_int_reg_wack, o_int_reg_rack;
  logic [DW-1:0] o_int_reg_data;
  logic [AW-1:0] o_int_reg_addr;
  logic          o_reg_wen, o_reg_ren;
  logic [AW-1:0] o_reg_addr;
  logic [DW-1:0] o_reg_wdata;
  logic          i_reg_ack = 1'b0;
  logic [DW-1:0] i_reg_rdata = '0;
  logic [1:0]    o_ovf_err;
  logic          o_tmo_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rsp_t          sb_q[$];
  logic [AW-1:0] strobe_addr_q[$];
  int            strobe_cyc_q[$];
  logic          strobe_wen_q[$];
  logic [DW-1:0] strobe_wdata_q[$];
  int            resp_events = 0;
  int            resp_cyc = 0;
  int            ovf_events = 0;
  int            ovf_cyc = 0;
  logic [1:0]    last_ovf = '0;

  logic          bank_en = 1'b1;
  int            req_cnt = 0;
  int            ack_cnt = 0;
  logic [DW-1:0] bank_data = '0;
  logic [DW-1:0] bank_mem [128];
  logic [DW-1:0] exp_mem  [128];

  reg_acc_arb #(
    .REG_AW(AW), .REG_DW(DW), .TMO_CYC(TMO), .TMO_CNT_W(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_spi_reg_wen(i_spi_reg_wen), .i_spi_reg_ren(i_spi_reg_ren),
    .i_spi_reg_addr(i_spi_reg_addr), .i_spi_reg_wdata(i_spi_reg_wdata),
    .o_spi_reg_wack(o_spi_reg_wack), .o_spi_reg_rack(o_spi_reg_rack),
    .o_spi_reg_data(o_spi_reg_data), .o_spi_reg_addr(o_spi_reg_addr),
    .i_int_reg_wen(i_int_reg_wen), .i_int_reg_ren(i_int_reg_ren),
    .i_int_reg_addr(i_int_reg_addr), .i_int_reg_wdata(i_int_reg_wdata),
    .o_int_reg_wack(o_int_reg_wack), .o_int_reg_rack(o_int_reg_rack),
    .o_int_reg_data(o_int_reg_data), .o_int_reg_addr(o_int_reg_addr),
    .o_reg_wen(o_reg_wen), .o_reg_ren(o_reg_ren),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
    .i_reg_ack(i_reg_ack), .i_reg_rdata(i_reg_rdata),
    .o_ovf_err(o_ovf_err), .o_tmo_err(o_tmo_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int a);
    return DW'((a * 37 + 11) & 255);
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) begin
      bank_mem[i] = init_val(i);
      exp_mem[i]  = init_val(i);
    end
  end

  // Bank model: ack (with data) in the cycle after each strobe.
  always @(posedge i_clk) begin
    #1;
    if (req_cnt != ack_cnt) begin
      i_reg_ack   = 1'b1;
      i_reg_rdata = bank_data;
      ack_cnt     = ack_cnt + 1;
    end else begin
      i_reg_ack   = 1'b0;
      i_reg_rdata = 8'hEE;
    end
  end

  // Strobe and overflow logger, plus the bank-side memory update.
  always @(negedge i_clk) begin
    if (o_reg_wen || o_reg_ren) begin
      strobe_addr_q.push_back(o_reg_addr);
      strobe_cyc_q.push_back(cyc);
      strobe_wen_q.push_back(o_reg_wen);
      strobe_wdata_q.push_back(o_reg_wdata);
      if (bank_en) begin
        if (o_reg_wen) begin
          bank_mem[o_reg_addr] = o_reg_wdata;
          bank_data = o_reg_wdata;
        end else begin
          bank_data = bank_mem[o_reg_addr];
        end
        req_cnt = req_cnt + 1;
      end
    end
    if (o_ovf_err != 2'b00) begin
      ovf_events = ovf_events + 1;
      ovf_cyc    = cyc;
      last_ovf   = o_ovf_err;
    end
  end

  // Scoreboard: every requester ack pops and checks one expected response.
  always @(negedge i_clk) begin
    rsp_t act_r;
    rsp_t exp_r;
    if (o_spi_reg_wack || o_spi_reg_rack || o_int_reg_wack || o_int_reg_rack) begin
      resp_events = resp_events + 1;
      resp_cyc    = cyc;
      if (o_int_reg_wack || o_int_reg_rack)
        act_r = {1'b1, o_int_reg_wack, o_int_reg_addr, o_int_reg_data, o_tmo_err};
      else
        act_r = {1'b0, o_spi_reg_wack, o_spi_reg_addr, o_spi_reg_data, o_tmo_err};
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_ack: got %h expected no response", act_r);
      end else begin
        exp_r = sb_q.pop_front();
        if (act_r !== exp_r) begin
          errors = errors + 1;
          $display("[TB] FAIL response: got %h expected %h (slot,wr,addr,data,tmo)", act_r, exp_r);
        end
      end
    end else if (o_tmo_err) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL stray_tmo_err: got 1 expected 0");
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_spi_reg_wen = 1'b0; i_spi_reg_ren = 1'b0;
    i_int_reg_wen = 1'b0; i_int_reg_ren = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    while (sb_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d pending responses expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    bank_en = 1'b1;
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    checks++;
    if ({o_spi_reg_wack, o_spi_reg_rack, o_int_reg_wack, o_int_reg_rack, o_reg_wen, o_reg_ren} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 000000",
               {o_spi_reg_wack, o_spi_reg_rack, o_int_reg_wack, o_int_reg_rack, o_reg_wen, o_reg_ren});
    end
    checks++;
    if ({o_spi_reg_data, o_spi_reg_addr, o_int_reg_data, o_int_reg_addr, o_reg_addr, o_reg_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_buses: got %h expected 0",
               {o_spi_reg_data, o_spi_reg_addr, o_int_reg_data, o_int_reg_addr, o_reg_addr, o_reg_wdata});
    end
    checks++;
    if ({o_ovf_err, o_tmo_err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_errs: got %b expected 000", {o_ovf_err, o_tmo_err});
    end
  endtask

  task automatic test_single_write();
    int n, base;
    base = strobe_addr_q.size();
    step();
    i_spi_reg_wen = 1'b1; i_spi_reg_addr = 7'h12; i_spi_reg_wdata = 8'hA5;
    n = cyc;
    sb_q.push_back('{slot: 1'b0, wr: 1'b1, addr: 7'h12, data: 8'hA5, tmo: 1'b0});
    step();
    clear_inputs();
    wait_drain(20, "single_write");
    checks++;
    if (strobe_addr_q.size() != base + 1) begin
      errors++;
      $display("[TB] FAIL write_strobe_count: got %0d expected 1", strobe_addr_q.size() - base);
    end else begin
      checks++;
      if ({strobe_wen_q[base], strobe_addr_q[base], strobe_wdata_q[base]} !== {1'b1, 7'h12, 8'hA5}) begin
        errors++;
        $display("[TB] FAIL write_strobe: got wen %b addr %h wdata %h expected wen 1 addr 12 wdata a5",
                 strobe_wen_q[base], strobe_addr_q[base], strobe_wdata_q[base]);
      end
      checks++;
      if (strobe_cyc_q[base] != n + 2) begin
        errors++;
        $display("[TB] FAIL write_strobe_cycle: got N+%0d expected N+2", strobe_cyc_q[base] - n);
      end
    end
    checks++;
    if (resp_cyc != n + 4) begin
      errors++;
      $display("[TB] FAIL write_ack_cycle: got N+%0d expected N+4", resp_cyc - n);
    end
    repeat (3) step();
    checks++;
    if ({o_spi_reg_data, o_spi_reg_addr, o_reg_addr, o_reg_wdata, o_reg_wen} !== {8'hA5, 7'h12, 7'h12, 8'hA5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hold_values: got data %h addr %h bank addr %h wdata %h wen %b expected a5 12 12 a5 0",
               o_spi_reg_data, o_spi_reg_addr, o_reg_addr, o_reg_wdata, o_reg_wen);
    end
  endtask

  task automatic test_simul_read();
    int base;
    do_reset();
    base = strobe_addr_q.size();
    step();
    i_spi_reg_ren = 1'b1; i_spi_reg_addr = 7'h05;
    i_int_reg_ren = 1'b1; i_int_reg_addr = 7'h06;
    sb_q.push_back('{slot: 1'b0, wr: 1'b0, addr: 7'h05, data: exp_mem[5], tmo: 1'b0});
    sb_q.push_back('{slot: 1'b1, wr: 1'b0, addr: 7'h06, data: exp_mem[6], tmo: 1'b0});
    step();
    clear_inputs();
    wait_drain(30, "simul_read");
    checks++;
    if (strobe_addr_q.size() != base + 2) begin
      errors++;
      $display("[TB] FAIL simul_strobe_count: got %0d expected 2", strobe_addr_q.size() - base);
    end else begin
      checks++;
      if ({strobe_addr_q[base], strobe_addr_q[base+1]} !== {7'h05, 7'h06}) begin
        errors++;
        $display("[TB] FAIL simul_order: got %h,%h expected 05,06", strobe_addr_q[base], strobe_addr_q[base+1]);
      end
      checks++;
      if (strobe_cyc_q[base+1] - strobe_cyc_q[base] != 4) begin
        errors++;
        $display("[TB] FAIL simul_spacing: got %0d expected 4", strobe_cyc_q[base+1] - strobe_cyc_q[base]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, ovf_base, s0, s1, budget;
    logic [AW-1:0] exp_a;
    do_reset();
    base = strobe_addr_q.size();
    ovf_base = ovf_events;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{slot: 1'b0, wr: 1'b0, addr: AW'(32 + i), data: exp_mem[32 + i], tmo: 1'b0});
      sb_q.push_back('{slot: 1'b1, wr: 1'b0, addr: AW'(64 + i), data: exp_mem[64 + i], tmo: 1'b0});
    end
    step();
    i_spi_reg_ren = 1'b1; i_spi_reg_addr = 7'h20;
    i_int_reg_ren = 1'b1; i_int_reg_addr = 7'h40;
    s0 = 1; s1 = 1;
    budget = 80;
    while (sb_q.size() > 0 && budget > 0) begin
      step();
      budget--;
      clear_inputs();
      if (o_spi_reg_rack && s0 < 4) begin
        i_spi_reg_ren = 1'b1; i_spi_reg_addr = AW'(32 + s0); s0++;
      end
      if (o_int_reg_rack && s1 < 4) begin
        i_int_reg_ren = 1'b1; i_int_reg_addr = AW'(64 + s1); s1++;
      end
    end
    clear_inputs();
    wait_drain(1, "back_to_back");
    checks++;
    if (strobe_addr_q.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL b2b_strobe_count: got %0d expected 8", strobe_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_a = (i % 2 == 0) ? AW'(32 + i / 2) : AW'(64 + i / 2);
        checks++;
        if (strobe_addr_q[base+i] !== exp_a) begin
          errors++;
          $display("[TB] FAIL b2b_grant_%0d: got addr %h expected %h", i, strobe_addr_q[base+i], exp_a);
        end
        if (i > 0) begin
          checks++;
          if (strobe_cyc_q[base+i] - strobe_cyc_q[base+i-1] != 4) begin
            errors++;
            $display("[TB] FAIL b2b_spacing_%0d: got %0d expected 4", i,
                     strobe_cyc_q[base+i] - strobe_cyc_q[base+i-1]);
          end
        end
      end
    end
    checks++;
    if (ovf_events != ovf_base) begin
      errors++;
      $display("[TB] FAIL b2b_no_ovf: got %0d overflow pulses expected 0", ovf_events - ovf_base);
    end
  endtask

  task automatic test_overflow();
    int n, ovf_base, rbase;
    do_reset();
    ovf_base = ovf_events;
    rbase = resp_events;
    step();
    i_spi_reg_ren = 1'b1; i_spi_reg_addr = 7'h07;
    n = cyc;
    sb_q.push_back('{slot: 1'b0, wr: 1'b0, addr: 7'h07, data: exp_mem[7], tmo: 1'b0});
    step();
    i_spi_reg_addr = 7'h08;
    step();
    clear_inputs();
    wait_drain(20, "overflow");
    repeat (10) step();
    checks++;
    if (ovf_events - ovf_base != 1) begin
      errors++;
      $display("[TB] FAIL ovf_count: got %0d expected 1", ovf_events - ovf_base);
    end
    checks++;
    if (last_ovf !== 2'b01 || ovf_cyc != n + 2) begin
      errors++;
      $display("[TB] FAIL ovf_pulse: got %b at N+%0d expected 01 at N+2", last_ovf, ovf_cyc - n);
    end
    checks++;
    if (resp_events - rbase != 1) begin
      errors++;
      $display("[TB] FAIL ovf_resp_count: got %0d expected 1", resp_events - rbase);
    end
  endtask

  task automatic test_timeout();
    int n, base, rbase;
    do_reset();
    bank_en = 1'b0;
    base = strobe_addr_q.size();
    rbase = resp_events;
    step();
    i_spi_reg_ren = 1'b1; i_spi_reg_addr = 7'h09;
    n = cyc;
    step();
    clear_inputs();
`ifdef REG_ARB_TMO_EN
    sb_q.push_back('{slot: 1'b0, wr: 1'b0, addr: 7'h09, data: 8'h00, tmo: 1'b1});
    wait_drain(40, "timeout");
    checks++;
    if (resp_cyc != n + 19) begin
      errors++;
      $display("[TB] FAIL timeout_cycle: got N+%0d expected N+19", resp_cyc - n);
    end
`else
    repeat (40) step();
    checks++;
    if (resp_events != rbase) begin
      errors++;
      $display("[TB] FAIL no_timeout_ack: got %0d responses expected 0", resp_events - rbase);
    end
`endif
    checks++;
    if (strobe_addr_q.size() != base + 1) begin
      errors++;
      $display("[TB] FAIL timeout_strobes: got %0d expected 1", strobe_addr_q.size() - base);
    end
    bank_en = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    int base, rbase;
    do_reset();
    bank_en = 1'b0;
    base = strobe_addr_q.size();
    rbase = resp_events;
    step();
    i_spi_reg_ren = 1'b1; i_spi_reg_addr = 7'h0A;
    step();
    clear_inputs();
    repeat (4) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_spi_reg_wack, o_spi_reg_rack, o_spi_reg_data, o_spi_reg_addr,
         o_int_reg_wack, o_int_reg_rack, o_int_reg_data, o_int_reg_addr,
         o_reg_wen, o_reg_ren, o_reg_addr, o_reg_wdata, o_ovf_err, o_tmo_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_in_wait_outputs: got %h expected 0",
               {o_spi_reg_wack, o_spi_reg_rack, o_spi_reg_data, o_spi_reg_addr,
                o_int_reg_wack, o_int_reg_rack, o_int_reg_data, o_int_reg_addr,
                o_reg_wen, o_reg_ren, o_reg_addr, o_reg_wdata, o_ovf_err, o_tmo_err});
    end
    bank_en = 1'b1;
    repeat (12) step();
    checks++;
    if (resp_events != rbase || strobe_addr_q.size() != base + 1) begin
      errors++;
      $display("[TB] FAIL reset_in_wait_abort: got %0d responses %0d strobes expected 0 responses 1 strobe",
               resp_events - rbase, strobe_addr_q.size() - base);
    end
  endtask

  initial begin
    $display("[TB] reg_acc_arb bench start");
    test_reset();
    test_single_write();
    test_simul_read();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_in_wait();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
